// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU-to-PWM sequencer.
// Default widths are exported so the top and sub-module agree without re-stating them.
package alu_ctrl_pkg;

  localparam int DEF_OP_W    = 3;
  localparam int DEF_RES_W   = 16;
  localparam int DEF_DWELL_W = 32;
  localparam int NUM_OPS     = 2**DEF_OP_W;
  localparam int DUTY_W      = DEF_RES_W / 2;
  localparam int DWELL_MIN   = 1;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    SAMPLE,
    WAIT_PERIOD,
    DWELL
  } seq_state_t;

endpackage

// File: rtl/alu_seq_ctrl_dwell_counter.sv
// Load/decrement down-counter timing one operation's dwell; a load of 0 becomes DWELL_MIN.
// expired_o marks the last dwell cycle, so a load of N gives exactly N decrement cycles.
module dwell_counter
  import alu_ctrl_pkg::*;
#(
  parameter int W = DEF_DWELL_W
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  input  logic         dec_i,
  output logic         expired_o
);

  logic [W-1:0] r_count;
  logic [W-1:0] w_load_val;

  assign w_load_val = (value_i == '0) ? W'(DWELL_MIN) : value_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_count <= '0;
    end else if (load_i) begin
      r_count <= w_load_val;
    end else if (dec_i && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign expired_o = (r_count == W'(DWELL_MIN));

endmodule

// File: rtl/alu_seq_ctrl.sv
// Steps the ALU mux through operations and commits each result to the LED PWM duties,
// changing duty only on a PWM period wrap so the LED never sees a partial period.
module alu_seq_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int OP_W    = DEF_OP_W,
  parameter int RES_W   = DEF_RES_W,
  parameter int DWELL_W = DEF_DWELL_W
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic               auto_i,
  input  logic [OP_W-1:0]    manual_op_i,
  input  logic [DWELL_W-1:0] dwell_i,
  input  logic [RES_W-1:0]   alu_result_i,
  input  logic               period_end_i,
  output logic [OP_W-1:0]    op_select_o,
  output logic [RES_W/2-1:0] duty_r_o,
  output logic [RES_W/2-1:0] duty_g_o,
  output logic               duty_valid_o,
  output logic               busy_o,
  output logic               op_done_o
);

  localparam int HALF_W = RES_W / 2;

  seq_state_t       r_state, w_state_nxt;
  logic [OP_W-1:0]  r_op, w_op_nxt;
  logic [RES_W-1:0] r_pending, w_pending_nxt;
  logic [RES_W-1:0] r_duty, w_duty_nxt;
  logic             r_duty_vld, w_duty_vld_nxt;
  logic             r_busy;
  logic             r_op_done, w_op_done_nxt;
  logic             w_cnt_load, w_cnt_dec, w_expired;

  dwell_counter #(.W(DWELL_W)) u_dwell (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .load_i    (w_cnt_load),
    .value_i   (dwell_i),
    .dec_i     (w_cnt_dec),
    .expired_o (w_expired)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state    <= IDLE;
      r_op       <= '0;
      r_pending  <= '0;
      r_duty     <= '0;
      r_duty_vld <= 1'b0;
      r_busy     <= 1'b0;
      r_op_done  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_op       <= w_op_nxt;
      r_pending  <= w_pending_nxt;
      r_duty     <= w_duty_nxt;
      r_duty_vld <= w_duty_vld_nxt;
      r_busy     <= (w_state_nxt != IDLE);
      r_op_done  <= w_op_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_op_nxt       = r_op;
    w_pending_nxt  = r_pending;
    w_duty_nxt     = r_duty;
    w_duty_vld_nxt = r_duty_vld;
    w_op_done_nxt  = 1'b0;
    w_cnt_load     = 1'b0;
    w_cnt_dec      = 1'b0;

    // Stop outranks every other event; duties and op select stay as the LEDs last saw them.
    if (stop_i) begin
      w_state_nxt = IDLE;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start_i) begin
            w_state_nxt = SELECT;
            w_op_nxt    = auto_i ? '0 : manual_op_i;
          end
        end
        SELECT: begin
          w_state_nxt = SAMPLE;
        end
        SAMPLE: begin
          w_pending_nxt = alu_result_i;
          w_state_nxt   = WAIT_PERIOD;
        end
        WAIT_PERIOD: begin
          if (period_end_i) begin
            w_duty_nxt     = r_pending;
            w_duty_vld_nxt = 1'b1;
            w_cnt_load     = 1'b1;
            w_state_nxt    = DWELL;
          end
        end
        DWELL: begin
          w_cnt_dec = 1'b1;
          if (w_expired) begin
            w_op_done_nxt = 1'b1;
            w_op_nxt      = auto_i ? r_op + OP_W'(1) : manual_op_i;
            w_state_nxt   = SELECT;
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  assign op_select_o  = r_op;
  assign duty_r_o     = r_duty[HALF_W-1:0];
  assign duty_g_o     = r_duty[RES_W-1:HALF_W];
  assign duty_valid_o = r_duty_vld;
  assign busy_o       = r_busy;
  assign op_done_o    = r_op_done;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scenario bench for alu_seq_ctrl: each task drives one feature and checks it against
// expectations derived from the sequencing rules (op order, commit-on-wrap, dwell length).
module tb_alu_seq_ctrl;

  localparam int OP_W    = 3;
  localparam int RES_W   = 16;
  localparam int DWELL_W = 32;
  localparam int DW      = RES_W / 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset, start, stop, auto_m, pe;
  logic [OP_W-1:0]    manual_op;
  logic [DWELL_W-1:0] dwell;
  logic [RES_W-1:0]   alu_res;
  logic [OP_W-1:0]    op_sel;
  logic [DW-1:0]      duty_r, duty_g;
  logic               duty_valid, busy, op_done;

  // ALU stand-in: either a per-op pattern or a fixed value chosen by the scenario.
  logic               use_op_model;
  logic [RES_W-1:0]   fixed_res;
  assign alu_res = use_op_model ? {5'h0, op_sel, 5'h0, op_sel} : fixed_res;

  int n_pass = 0;
  int n_chk  = 0;

  alu_seq_ctrl dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .start_i      (start),
    .stop_i       (stop),
    .auto_i       (auto_m),
    .manual_op_i  (manual_op),
    .dwell_i      (dwell),
    .alu_result_i (alu_res),
    .period_end_i (pe),
    .op_select_o  (op_sel),
    .duty_r_o     (duty_r),
    .duty_g_o     (duty_g),
    .duty_valid_o (duty_valid),
    .busy_o       (busy),
    .op_done_o    (op_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start = 0; stop = 0; pe = 0; reset = 1;
    step();
    reset = 0;
  endtask

  task automatic test_reset();
    logic bad;
    do_reset();
    auto_m = 0; manual_op = 3'd2; use_op_model = 0; fixed_res = 16'h5A3C; dwell = 32'd50;
    start = 1; step(); start = 0;
    step(); step();
    pe = 1; step(); pe = 0;
    step(); step();
    n_chk++; if (duty_r !== 8'h3C) $display("FAIL pre_reset_duty_r got %0h want 3c", duty_r); else n_pass++;
    n_chk++; if (duty_g !== 8'h5A) $display("FAIL pre_reset_duty_g got %0h want 5a", duty_g); else n_pass++;
    reset = 1; step(); step(); step(); reset = 0;
    n_chk++; if (op_sel !== 3'd0) $display("FAIL reset_op_sel got %0h want 0", op_sel); else n_pass++;
    n_chk++; if (duty_r !== 8'h00) $display("FAIL reset_duty_r got %0h want 0", duty_r); else n_pass++;
    n_chk++; if (duty_g !== 8'h00) $display("FAIL reset_duty_g got %0h want 0", duty_g); else n_pass++;
    n_chk++; if (duty_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", duty_valid); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_chk++; if (op_done !== 1'b0) $display("FAIL reset_op_done got %b want 0", op_done); else n_pass++;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (busy !== 1'b0) bad = 1;
    end
    n_chk++; if (bad !== 1'b0) $display("FAIL idle_busy got busy=1 want 0"); else n_pass++;
  endtask

  task automatic test_auto_sweep();
    int              commit_cyc;
    int              dones;
    logic [OP_W-1:0] exp_op, nxt_op;
    logic            prev_v;
    logic [DW-1:0]   prev_r, prev_g;
    do_reset();
    auto_m = 1; use_op_model = 1; dwell = 32'd10;
    start = 1; step(); start = 0;
    n_chk++; if (op_sel !== 3'd0) $display("FAIL auto_first_op got %0d want 0", op_sel); else n_pass++;
    n_chk++; if (busy !== 1'b1) $display("FAIL auto_busy got %b want 1", busy); else n_pass++;
    commit_cyc = -100; dones = 0; exp_op = 0;
    prev_v = duty_valid; prev_r = duty_r; prev_g = duty_g;
    for (int cyc = 0; cyc < 3000 && dones < 9; cyc++) begin
      pe = ((cyc % 16) == 15);
      step();
      if (duty_valid && (!prev_v || duty_r !== prev_r || duty_g !== prev_g)) begin
        n_chk++; if (pe !== 1'b1) $display("FAIL auto_commit_on_wrap cyc %0d period_end=%b want 1", cyc, pe); else n_pass++;
        n_chk++; if (duty_r !== {5'h0, exp_op} || duty_g !== {5'h0, exp_op})
          $display("FAIL auto_commit_val got r=%0h g=%0h want %0h", duty_r, duty_g, exp_op); else n_pass++;
        commit_cyc = cyc;
      end
      if (op_done) begin
        nxt_op = exp_op + 3'd1;
        n_chk++; if (cyc - commit_cyc != 10) $display("FAIL auto_dwell_len got %0d want 10", cyc - commit_cyc); else n_pass++;
        n_chk++; if (op_sel !== nxt_op) $display("FAIL auto_next_op got %0d want %0d", op_sel, nxt_op); else n_pass++;
        exp_op = nxt_op;
        dones++;
      end
      prev_v = duty_valid; prev_r = duty_r; prev_g = duty_g;
    end
    pe = 0;
    n_chk++; if (dones != 9) $display("FAIL auto_done_count got %0d want 9", dones); else n_pass++;
    stop = 1; step(); stop = 0;
    n_chk++; if (busy !== 1'b0) $display("FAIL auto_stop_busy got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_manual();
    logic            seen, early;
    logic [OP_W-1:0] m;
    logic [RES_W-1:0] r;
    do_reset();
    auto_m = 0; manual_op = 3'd3; use_op_model = 0; fixed_res = 16'hA50F; dwell = 32'd20;
    start = 1; step(); start = 0;
    n_chk++; if (op_sel !== 3'd3) $display("FAIL man_op got %0d want 3", op_sel); else n_pass++;
    step(); step();
    pe = 1; step(); pe = 0;
    n_chk++; if (duty_g !== 8'hA5) $display("FAIL man_duty_g got %0h want a5", duty_g); else n_pass++;
    n_chk++; if (duty_r !== 8'h0F) $display("FAIL man_duty_r got %0h want 0f", duty_r); else n_pass++;
    n_chk++; if (duty_valid !== 1'b1) $display("FAIL man_valid got %b want 1", duty_valid); else n_pass++;
    for (int i = 0; i < 5; i++) step();
    manual_op = 3'd6;
    seen = 0; early = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (op_done) begin
        seen = 1;
        n_chk++; if (op_sel !== 3'd6) $display("FAIL man_track got %0d want 6", op_sel); else n_pass++;
      end else if (op_sel !== 3'd3) begin
        early = 1;
      end
    end
    n_chk++; if (!seen) $display("FAIL man_done_timeout got none want op_done"); else n_pass++;
    n_chk++; if (early) $display("FAIL man_early_change got change want hold 3"); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      m = 3'($urandom_range(0, 7));
      r = 16'($urandom);
      dwell = 32'($urandom_range(1, 8));
      fixed_res = r;
      step(); step();
      pe = 1; step(); pe = 0;
      n_chk++; if ({duty_g, duty_r} !== r) $display("FAIL man_rand_commit got %0h want %0h", {duty_g, duty_r}, r); else n_pass++;
      manual_op = m;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
        step();
        if (op_done) seen = 1;
      end
      n_chk++; if (!seen || op_sel !== m) $display("FAIL man_rand_op got %0d done=%b want %0d", op_sel, seen, m); else n_pass++;
    end
    stop = 1; step(); stop = 0;
  endtask

  task automatic test_boundary();
    do_reset();
    auto_m = 0; manual_op = 3'd1; use_op_model = 0; fixed_res = 16'h1234; dwell = 32'd0;
    start = 1; step(); start = 0;
    step(); step();
    pe = 1; step(); pe = 0;
    n_chk++; if ({duty_g, duty_r} !== 16'h1234) $display("FAIL bnd_commit got %0h want 1234", {duty_g, duty_r}); else n_pass++;
    n_chk++; if (op_done !== 1'b0) $display("FAIL bnd_done_early got %b want 0", op_done); else n_pass++;
    step();
    n_chk++; if (op_done !== 1'b1) $display("FAIL bnd_dwell0_len got %b want 1", op_done); else n_pass++;
    fixed_res = 16'hBEEF;
    pe = 1; step(); step(); pe = 0;
    n_chk++; if ({duty_g, duty_r} !== 16'h1234) $display("FAIL bnd_pe_ignored got %0h want 1234", {duty_g, duty_r}); else n_pass++;
    step();
    n_chk++; if ({duty_g, duty_r} !== 16'h1234) $display("FAIL bnd_wait_hold got %0h want 1234", {duty_g, duty_r}); else n_pass++;
    pe = 1; step(); pe = 0;
    n_chk++; if ({duty_g, duty_r} !== 16'hBEEF) $display("FAIL bnd_next_pulse got %0h want beef", {duty_g, duty_r}); else n_pass++;
    stop = 1; step(); stop = 0;
  endtask

  task automatic test_stop_collisions();
    do_reset();
    auto_m = 0; manual_op = 3'd5; use_op_model = 0; fixed_res = 16'h1122; dwell = 32'd2;
    start = 1; step(); start = 0;
    step(); step();
    pe = 1; step(); pe = 0;
    step(); step();
    n_chk++; if (op_done !== 1'b1) $display("FAIL stop_setup_done got %b want 1", op_done); else n_pass++;
    fixed_res = 16'h3344;
    step(); step();
    stop = 1; pe = 1; step(); stop = 0; pe = 0;
    n_chk++; if (busy !== 1'b0) $display("FAIL stop_pe_busy got %b want 0", busy); else n_pass++;
    n_chk++; if ({duty_g, duty_r} !== 16'h1122) $display("FAIL stop_pe_nocommit got %0h want 1122", {duty_g, duty_r}); else n_pass++;
    n_chk++; if (duty_valid !== 1'b1) $display("FAIL stop_valid_held got %b want 1", duty_valid); else n_pass++;
    manual_op = 3'd2;
    pe = 1; step(); step(); pe = 0;
    n_chk++; if (op_sel !== 3'd5 || {duty_g, duty_r} !== 16'h1122)
      $display("FAIL stop_idle_hold got op=%0d duty=%0h want 5/1122", op_sel, {duty_g, duty_r}); else n_pass++;
    start = 1; stop = 1; step(); start = 0; stop = 0;
    step();
    n_chk++; if (busy !== 1'b0) $display("FAIL start_stop_idle got %b want 0", busy); else n_pass++;
    start = 1; step();
    n_chk++; if (busy !== 1'b1 || op_sel !== 3'd2) $display("FAIL restart got busy=%b op=%0d want 1/2", busy, op_sel); else n_pass++;
    step(); step();
    pe = 1; step(); pe = 0; start = 0;
    n_chk++; if ({duty_g, duty_r} !== 16'h3344) $display("FAIL start_while_busy got %0h want 3344", {duty_g, duty_r}); else n_pass++;
    stop = 1; step(); stop = 0;
  endtask

  task automatic test_wrap_long_dwell();
    logic bad;
    do_reset();
    auto_m = 0; manual_op = 3'd7; use_op_model = 1; dwell = 32'd1;
    start = 1; step(); start = 0;
    step(); step();
    pe = 1; step(); pe = 0;
    n_chk++; if (duty_r !== 8'h07 || duty_g !== 8'h07) $display("FAIL wrap_op7 got %0h/%0h want 7", duty_r, duty_g); else n_pass++;
    auto_m = 1; dwell = 32'hFFFF_FFFF;
    step();
    n_chk++; if (op_done !== 1'b1 || op_sel !== 3'd0) $display("FAIL wrap_to_0 got done=%b op=%0d want 1/0", op_done, op_sel); else n_pass++;
    step(); step();
    pe = 1; step(); pe = 0;
    n_chk++; if (duty_r !== 8'h00 || duty_valid !== 1'b1) $display("FAIL wrap_commit0 got %0h want 0", duty_r); else n_pass++;
    dwell = 32'd1;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      pe = 1'($urandom_range(0, 1));
      step();
      if (op_done !== 1'b0 || busy !== 1'b1) bad = 1;
    end
    pe = 0;
    n_chk++; if (bad) $display("FAIL long_dwell got early op_done or idle want hold"); else n_pass++;
    stop = 1; step(); stop = 0;
  endtask

  initial begin
    reset = 1; start = 0; stop = 0; auto_m = 0; pe = 0;
    manual_op = '0; dwell = '0; use_op_model = 0; fixed_res = '0;
    step(); step();
    test_reset();
    test_auto_sweep();
    test_manual();
    test_boundary();
    test_stop_collisions();
    test_wrap_long_dwell();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
